// File: rtl/wr2_frame_sink_if.sv
// Frame stream input (strobe, word, region select) and SDRAM write channel of wr2_frame_sink.
// The sink uses the slave view; the producer/SDRAM side uses the master view.
interface wr2_frame_sink_if #(
   parameter int DATA_W = 16,
   parameter int ADDR_W = 21
);
   logic              wr2;
   logic [DATA_W-1:0] wr2_data;
   logic [1:0]        frame_sel;
   logic              sdr_wr_req;
   logic [ADDR_W-1:0] sdr_addr;
   logic [DATA_W-1:0] sdr_data;
   logic              sdr_wr_ack;

   modport master (
      output wr2, wr2_data, frame_sel, sdr_wr_ack,
      input  sdr_wr_req, sdr_addr, sdr_data
   );

   modport slave (
      input  wr2, wr2_data, frame_sel, sdr_wr_ack,
      output sdr_wr_req, sdr_addr, sdr_data
   );
endinterface

// File: rtl/wr2_frame_sink.sv
// Purpose: captures one frame from the unstallable wr2 stream and writes it to SDRAM ({sel, index} addressing).
// Latency: a strobe into an empty FIFO with an idle output stage drives req/addr/data the next cycle; 1 word/cycle sustained.
// Backpressure: FIFO absorbs ack stalls, overflowing words are dropped (sticky o_overflow). WR2_SINK_CHECKSUM_EN adds o_checksum.
module wr2_frame_sink #(
   parameter int DATA_W       = 16,
   parameter int FIFO_DEPTH   = 16,
   parameter int FRAME_PIXELS = 307200,
   parameter int ADDR_W       = 21
) (
   input  logic                  i_clk,
   input  logic                  i_rst,
   wr2_frame_sink_if.slave       bus,
   output logic                  o_busy,
   output logic                  o_frame_done,
   output logic                  o_overflow,
   output logic [18:0]           o_words_in,
   output logic [15:0]           o_checksum
);
   localparam int AW    = $clog2(FIFO_DEPTH);
   localparam int PW    = AW + 1;
   localparam int IDX_W = ADDR_W - 2;
   localparam logic [18:0]      LAST_WORD = 19'(FRAME_PIXELS - 1);
   localparam bit               ONE_WORD  = (FRAME_PIXELS == 1);
   localparam logic [IDX_W-1:0] IDX_ONE   = {{(IDX_W-1){1'b0}}, 1'b1};

   typedef enum logic [1:0] {IDLE, STREAM, DRAIN, DONE} state_t;

   typedef struct packed {
      logic              req;
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] dat;
   } wr_stage_t;

   state_t            state_q, state_d;
   wr_stage_t         stage_q, stage_d;
   logic [1:0]        sel_q, sel_d;
   logic [18:0]       words_q, words_d;
   logic [IDX_W-1:0]  idx_q, idx_d;
   logic              ovf_q, ovf_d;
   logic [PW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [DATA_W-1:0] mem_q [FIFO_DEPTH];

   logic             fifo_empty, fifo_full, ack_fire, start, take;
   logic             load, bypass, pop, fifo_wr, drop;
   logic [1:0]       sel_eff;
   logic [IDX_W-1:0] idx_eff;

   always_comb begin
      fifo_empty = (wr_ptr_q == rd_ptr_q);
      fifo_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
      ack_fire   = stage_q.req && bus.sdr_wr_ack;
      start      = (state_q == IDLE) && bus.wr2;
      take       = start || ((state_q == STREAM) && bus.wr2);
      // Output stage refills when empty or being acked; an empty FIFO lets the incoming word bypass it.
      load       = (!stage_q.req || ack_fire) && (!fifo_empty || take);
      bypass     = load && fifo_empty;
      pop        = load && !fifo_empty;
      fifo_wr    = take && !bypass && (!fifo_full || pop);
      drop       = take && !bypass && !fifo_wr;
      sel_eff    = start ? bus.frame_sel : sel_q;
      idx_eff    = start ? '0 : idx_q;
   end

   always_comb begin
      state_d  = state_q;
      stage_d  = stage_q;
      sel_d    = sel_eff;
      idx_d    = idx_eff;
      words_d  = words_q;
      ovf_d    = ovf_q || drop;
      wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, fifo_wr};
      rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, pop};

      if (start) begin
         words_d = 19'd1;
         ovf_d   = 1'b0;
      end else if (take) begin
         words_d = words_q + 19'd1;
      end

      if (load) begin
         stage_d.req  = 1'b1;
         stage_d.addr = {sel_eff, idx_eff};
         stage_d.dat  = bypass ? bus.wr2_data : mem_q[rd_ptr_q[AW-1:0]];
         idx_d        = idx_eff + IDX_ONE;
      end else if (ack_fire) begin
         stage_d.req = 1'b0;
      end

      case (state_q)
         IDLE:    if (start) state_d = ONE_WORD ? DRAIN : STREAM;
         STREAM:  if (take && (words_q == LAST_WORD)) state_d = DRAIN;
         DRAIN:   if (fifo_empty && !stage_q.req) state_d = DONE;
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q  <= IDLE;
         stage_q  <= '0;
         sel_q    <= '0;
         idx_q    <= '0;
         words_q  <= '0;
         ovf_q    <= 1'b0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         state_q  <= state_d;
         stage_q  <= stage_d;
         sel_q    <= sel_d;
         idx_q    <= idx_d;
         words_q  <= words_d;
         ovf_q    <= ovf_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
      end
   end

   // Storage needs no reset: validity is carried entirely by the pointers.
   always_ff @(posedge i_clk) begin
      if (fifo_wr) mem_q[wr_ptr_q[AW-1:0]] <= bus.wr2_data;
   end

`ifdef WR2_SINK_CHECKSUM_EN
   logic [15:0] csum_q, csum_d;

   always_comb begin
      csum_d = csum_q;
      if (start)         csum_d = '0;
      else if (ack_fire) csum_d = csum_q + 16'(stage_q.dat);
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) csum_q <= '0;
      else       csum_q <= csum_d;
   end

   assign o_checksum = csum_q;
`else
   assign o_checksum = '0;
`endif

   assign bus.sdr_wr_req = stage_q.req;
   assign bus.sdr_addr   = stage_q.addr;
   assign bus.sdr_data   = stage_q.dat;
   assign o_busy         = (state_q == STREAM) || (state_q == DRAIN);
   assign o_frame_done   = (state_q == DONE);
   assign o_overflow     = ovf_q;
   assign o_words_in     = words_q;
endmodule

// File: tb/tb_wr2_frame_sink.sv
// Directed bench for wr2_frame_sink (FRAME_PIXELS=8, FIFO_DEPTH=4): vector table for a basic frame,
// then hand sequences for back-pressure, overflow, full push+pop, gaps/extras and reset mid-frame.
module tb_wr2_frame_sink;
   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   wr2_frame_sink_if #(.DATA_W(16), .ADDR_W(21)) bus ();

   logic        busy, frame_done, ovf;
   logic [18:0] words;
   logic [15:0] csum;

   wr2_frame_sink #(
      .DATA_W(16), .FIFO_DEPTH(4), .FRAME_PIXELS(8), .ADDR_W(21)
   ) dut (
      .i_clk(clk), .i_rst(rst), .bus(bus),
      .o_busy(busy), .o_frame_done(frame_done), .o_overflow(ovf),
      .o_words_in(words), .o_checksum(csum)
   );

`ifdef WR2_SINK_CHECKSUM_EN
   localparam logic [15:0] CS_BASIC = 16'h0024;
   localparam logic [15:0] CS_OVF   = 16'h00AA;
`else
   localparam logic [15:0] CS_BASIC = 16'h0000;
   localparam logic [15:0] CS_OVF   = 16'h0000;
`endif

   int total = 0;
   int bad   = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   typedef struct packed {
      logic [20:0] addr;
      logic [15:0] dat;
   } wr_t;

   wr_t  wr_q[$];
   int   done_cnt  = 0;
   logic hold_prev = 1'b0;
   wr_t  hold_w;

   // Write monitor plus hold-stability check while req is stalled.
   always @(negedge clk) begin
      if (!rst) begin
         if (hold_prev)
            chk("hold_stable", {bus.sdr_wr_req, bus.sdr_addr, bus.sdr_data}, {1'b1, hold_w});
         if (bus.sdr_wr_req && bus.sdr_wr_ack) wr_q.push_back({bus.sdr_addr, bus.sdr_data});
         if (frame_done) done_cnt++;
         hold_prev = bus.sdr_wr_req && !bus.sdr_wr_ack;
         hold_w    = {bus.sdr_addr, bus.sdr_data};
      end else begin
         hold_prev = 1'b0;
      end
   end

   task automatic step(input logic w, input logic [15:0] d, input logic a);
      bus.wr2        = w;
      bus.wr2_data   = d;
      bus.sdr_wr_ack = a;
      @(posedge clk);
      #1;
   endtask

   task automatic wait_done(input string name);
      int n;
      bus.wr2 = 1'b0;
      for (n = 0; n < 200; n++) begin
         @(negedge clk);
         if (frame_done) break;
      end
      chk({name, "_done_seen"}, 64'(n < 200), 64'd1);
      @(posedge clk);
      #1;
   endtask

   task automatic check_writes(input string name, input int n, input logic [1:0] sel,
                               input logic [15:0] d0);
      wr_t e;
      chk({name, "_count"}, 64'(wr_q.size()), 64'(n));
      for (int i = 0; i < n && i < wr_q.size(); i++) begin
         e.addr = {sel, 19'(i)};
         e.dat  = d0 + 16'(i);
         chk($sformatf("%s_wr%0d", name, i), 64'(wr_q[i]), 64'(e));
      end
      wr_q.delete();
   endtask

   typedef struct packed {
      logic        wr2;
      logic [15:0] dat;
      logic        ack;
      logic        req;
      logic [20:0] addr;
      logic [15:0] sdat;
      logic        busy;
      logic        done;
      logic [18:0] words;
   } vec_t;

   vec_t tbl [12];

   initial begin
      int          d_snap;
      int          k;
      logic [11:0] gap_pat;

      // Basic frame, sel=2, ack high; rows 8..10 carry extra strobes in DRAIN/DONE.
      tbl[0] = '{1'b1, 16'h0001, 1'b1, 1'b0, 21'h000000, 16'h0000, 1'b0, 1'b0, 19'd0};
      for (int i = 1; i < 8; i++)
         tbl[i] = '{1'b1, 16'(i + 1), 1'b1, 1'b1, 21'h100000 + 21'(i - 1), 16'(i), 1'b1, 1'b0, 19'(i)};
      tbl[8]  = '{1'b1, 16'h0009, 1'b1, 1'b1, 21'h100007, 16'h0008, 1'b1, 1'b0, 19'd8};
      tbl[9]  = '{1'b1, 16'h000A, 1'b1, 1'b0, 21'h000000, 16'h0000, 1'b1, 1'b0, 19'd8};
      tbl[10] = '{1'b1, 16'h000B, 1'b1, 1'b0, 21'h000000, 16'h0000, 1'b0, 1'b1, 19'd8};
      tbl[11] = '{1'b0, 16'h0000, 1'b1, 1'b0, 21'h000000, 16'h0000, 1'b0, 1'b0, 19'd8};

      rst            = 1'b1;
      bus.wr2        = 1'b0;
      bus.wr2_data   = '0;
      bus.frame_sel  = 2'd0;
      bus.sdr_wr_ack = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      chk("reset_stage", {bus.sdr_wr_req, bus.sdr_addr, bus.sdr_data}, 64'd0);
      chk("reset_status", {busy, frame_done, ovf, words, csum}, 64'd0);
      @(posedge clk);
      #1;

      bus.frame_sel = 2'd2;
      d_snap = done_cnt;
      for (int i = 0; i < 12; i++) begin
         bus.wr2        = tbl[i].wr2;
         bus.wr2_data   = tbl[i].dat;
         bus.sdr_wr_ack = tbl[i].ack;
         @(negedge clk);
         chk($sformatf("vec%0d_ctl", i), {bus.sdr_wr_req, busy, frame_done, words},
             {tbl[i].req, tbl[i].busy, tbl[i].done, tbl[i].words});
         if (tbl[i].req)
            chk($sformatf("vec%0d_dat", i), {bus.sdr_addr, bus.sdr_data}, {tbl[i].addr, tbl[i].sdat});
         @(posedge clk);
         #1;
      end
      check_writes("basic", 8, 2'd2, 16'h0001);
      chk("basic_csum", csum, CS_BASIC);
      chk("basic_done_once", 64'(done_cnt - d_snap), 64'd1);

      // Back-pressure: ack low for three cycles mid-burst.
      bus.frame_sel = 2'd1;
      d_snap = done_cnt;
      for (int i = 0; i < 8; i++) step(1'b1, 16'h0010 + 16'(i), !(i >= 2 && i <= 4));
      bus.sdr_wr_ack = 1'b1;
      wait_done("bp");
      check_writes("bp", 8, 2'd1, 16'h0010);
      chk("bp_no_overflow", ovf, 1'b0);
      chk("bp_done_once", 64'(done_cnt - d_snap), 64'd1);

      // Overflow: ack held low through 8 strobes.
      bus.frame_sel = 2'd3;
      d_snap = done_cnt;
      for (int i = 0; i < 8; i++) step(1'b1, 16'h0020 + 16'(i), 1'b0);
      bus.wr2 = 1'b0;
      @(negedge clk);
      chk("ovf_stalled", {ovf, words, busy, bus.sdr_wr_req, bus.sdr_data},
          {1'b1, 19'd8, 1'b1, 1'b1, 16'h0020});
      @(posedge clk);
      #1;
      bus.sdr_wr_ack = 1'b1;
      wait_done("ovf");
      check_writes("ovf", 5, 2'd3, 16'h0020);
      chk("ovf_sticky", {ovf, words}, {1'b1, 19'd8});
      chk("ovf_csum", csum, CS_OVF);
      chk("ovf_done_once", 64'(done_cnt - d_snap), 64'd1);

      // Full FIFO: push and ack in the same cycle must not drop.
      bus.frame_sel = 2'd0;
      for (int i = 0; i < 8; i++) step(1'b1, 16'h0030 + 16'(i), i >= 5);
      bus.wr2 = 1'b0;
      @(negedge clk);
      chk("full_pushpop", {ovf, words}, {1'b0, 19'd8});
      @(posedge clk);
      #1;
      wait_done("full");
      check_writes("full", 8, 2'd0, 16'h0030);

      // Gaps within the frame, then three extra strobes.
      bus.frame_sel = 2'd2;
      d_snap  = done_cnt;
      gap_pat = 12'b1101_1100_1101;
      k = 0;
      for (int i = 0; i < 12; i++) begin
         step(gap_pat[i], 16'h0040 + 16'(k), 1'b1);
         if (gap_pat[i]) k++;
      end
      repeat (3) step(1'b1, 16'h0099, 1'b1);
      repeat (2) step(1'b0, 16'h0000, 1'b1);
      @(negedge clk);
      chk("gap_idle", {busy, words}, {1'b0, 19'd8});
      @(posedge clk);
      #1;
      chk("gap_done_once", 64'(done_cnt - d_snap), 64'd1);
      check_writes("gap", 8, 2'd2, 16'h0040);

      // Reset after 3 of 8 words, then a clean frame.
      bus.frame_sel = 2'd1;
      d_snap = done_cnt;
      for (int i = 0; i < 3; i++) step(1'b1, 16'h0050 + 16'(i), 1'b1);
      rst = 1'b1;
      step(1'b0, 16'h0000, 1'b1);
      rst = 1'b0;
      @(negedge clk);
      chk("rst_mid", {bus.sdr_wr_req, busy, frame_done, words}, 64'd0);
      @(posedge clk);
      #1;
      repeat (3) step(1'b0, 16'h0000, 1'b1);
      chk("rst_no_done", 64'(done_cnt - d_snap), 64'd0);
      wr_q.delete();
      for (int i = 0; i < 8; i++) step(1'b1, 16'h0060 + 16'(i), 1'b1);
      wait_done("rst_new");
      check_writes("rst_new", 8, 2'd1, 16'h0060);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish, total=%0d bad=%0d", total, bad);
      $fatal(1);
   end
endmodule
